// File: rtl/status_arbiter_if.sv
// Bundle of the four requester channels and the merged output stream.
// The arbiter connects through the slave modport. Requesters and the
// downstream consumer connect through the master modport.
interface status_arbiter_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] info_in_id0;
    logic [DATA_W-1:0] info_in_id1;
    logic [DATA_W-1:0] info_in_id2;
    logic [DATA_W-1:0] info_in_id3;
    logic              valid_in_id0;
    logic              valid_in_id1;
    logic              valid_in_id2;
    logic              valid_in_id3;
    logic              busy_id0;
    logic              busy_id1;
    logic              busy_id2;
    logic              busy_id3;
    logic [DATA_W-1:0] info_out;
    logic              valid_out;
    logic [1:0]        id_out;
    logic              downstream_busy;

    modport master (
        output info_in_id0, info_in_id1, info_in_id2, info_in_id3,
        output valid_in_id0, valid_in_id1, valid_in_id2, valid_in_id3,
        output downstream_busy,
        input  busy_id0, busy_id1, busy_id2, busy_id3,
        input  info_out, valid_out, id_out
    );

    modport slave (
        input  info_in_id0, info_in_id1, info_in_id2, info_in_id3,
        input  valid_in_id0, valid_in_id1, valid_in_id2, valid_in_id3,
        input  downstream_busy,
        output busy_id0, busy_id1, busy_id2, busy_id3,
        output info_out, valid_out, id_out
    );
endinterface

// File: rtl/status_arbiter.sv
// Four-channel round-robin merge of status words into one registered stream.
// Each channel owns a one-entry slot. The slot's full flag is that channel's
// busy, so a requester is released as soon as its word is captured. Only
// registered slot contents are arbitrated, which keeps busy free of any
// combinational path from valid_in or downstream_busy.
module status_arbiter #(
    parameter int DATA_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    status_arbiter_if.slave  bus
);

    logic [DATA_W-1:0] w_info_in [4];
    logic [3:0]        w_valid_in;
    logic [3:0]        w_capture;
    logic              w_load;
    logic [1:0]        w_grant;
    logic [1:0]        w_cand;
    logic              w_found;

    logic [3:0]        r_full;
    logic [DATA_W-1:0] r_data [4];
    logic [1:0]        r_last;
    logic              r_valid_out;
    logic [DATA_W-1:0] r_info_out;
    logic [1:0]        r_id_out;

    assign w_info_in[0] = bus.info_in_id0;
    assign w_info_in[1] = bus.info_in_id1;
    assign w_info_in[2] = bus.info_in_id2;
    assign w_info_in[3] = bus.info_in_id3;
    assign w_valid_in   = {bus.valid_in_id3, bus.valid_in_id2,
                           bus.valid_in_id1, bus.valid_in_id0};

    // A full slot blocks capture, so capture and release never meet on one slot.
    assign w_capture = w_valid_in & ~r_full;

    // The output register accepts a new word when it is empty or being drained.
    assign w_load = (~r_valid_out | ~bus.downstream_busy) & (|r_full);

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_grant = r_last;
        w_cand  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + k[1:0];
            if (!w_found && r_full[w_cand]) begin
                w_grant = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // Slot occupancy: set on capture, cleared when the slot is loaded out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_load && (w_grant == 2'(n))) begin
                    r_full[n] <= 1'b0;
                end else if (w_capture[n]) begin
                    r_full[n] <= 1'b1;
                end
            end
        end
    end

    // Slot payload; contents are meaningless while the slot is empty.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_capture[n]) begin
                r_data[n] <= w_info_in[n];
            end
        end
    end

    // Output register and round-robin pointer; frozen while valid and stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_info_out  <= '0;
            r_id_out    <= '0;
            r_last      <= 2'd3;
        end else if (w_load) begin
            r_valid_out <= 1'b1;
            r_info_out  <= r_data[w_grant];
            r_id_out    <= w_grant;
            r_last      <= w_grant;
        end else if (r_valid_out && !bus.downstream_busy) begin
            r_valid_out <= 1'b0;
        end
    end

    assign bus.busy_id0  = r_full[0];
    assign bus.busy_id1  = r_full[1];
    assign bus.busy_id2  = r_full[2];
    assign bus.busy_id3  = r_full[3];
    assign bus.valid_out = r_valid_out;
    assign bus.info_out  = r_info_out;
    assign bus.id_out    = r_id_out;

endmodule

// File: tb/tb_status_arbiter.sv
// Directed bench for status_arbiter. Requesters are modelled as per-channel
// word queues that hold valid/info until accepted; accepted output words are
// logged in order.
module tb_status_arbiter;
    localparam int DW = 128;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] info;
    } rx_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ds_busy = 1'b0;
    logic [3:0]    tb_valid = '0;
    logic [DW-1:0] tb_info [4];
    logic [DW-1:0] q [4][$];
    rx_t           rx[$];
    int            acc0[$];
    int            tick_no = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [3:0]    w_busy;

    status_arbiter_if #(.DATA_W(DW)) sif ();

    assign sif.info_in_id0     = tb_info[0];
    assign sif.info_in_id1     = tb_info[1];
    assign sif.info_in_id2     = tb_info[2];
    assign sif.info_in_id3     = tb_info[3];
    assign sif.valid_in_id0    = tb_valid[0];
    assign sif.valid_in_id1    = tb_valid[1];
    assign sif.valid_in_id2    = tb_valid[2];
    assign sif.valid_in_id3    = tb_valid[3];
    assign sif.downstream_busy = ds_busy;
    assign w_busy = {sif.busy_id3, sif.busy_id2, sif.busy_id1, sif.busy_id0};

    status_arbiter #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] wd(input int ch, input int k);
        return {64'hC0DE_0000_0000_0000 + 64'(ch), 64'hFACE_0000_0000_0000 + 64'(k)};
    endfunction

    // One clock: present queue heads, predict transfers, advance past the edge.
    task automatic tick();
        logic [3:0]    acc;
        logic          oxfer;
        rx_t           e;
        logic [DW-1:0] tmp;
        for (int n = 0; n < 4; n++) begin
            tb_valid[n] = (q[n].size() > 0);
            tb_info[n]  = tb_valid[n] ? q[n][0] : '0;
        end
        acc    = tb_valid & ~w_busy & {4{~rst}};
        oxfer  = sif.valid_out & ~ds_busy & ~rst;
        e.id   = sif.id_out;
        e.info = sif.info_out;
        @(posedge clk);
        #1;
        tick_no++;
        for (int n = 0; n < 4; n++) begin
            if (acc[n]) begin
                tmp = q[n].pop_front();
                if (n == 0) acc0.push_back(tick_no);
            end
        end
        if (oxfer) rx.push_back(e);
    endtask

    task automatic drain(input int n, input int max_ticks, output bit ok);
        for (int i = 0; i < max_ticks; i++) begin
            if (rx.size() >= n) break;
            tick();
        end
        ok = (rx.size() >= n);
    endtask

    task automatic do_reset();
        for (int n = 0; n < 4; n++) q[n].delete();
        ds_busy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx.delete();
        acc0.delete();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 4; n++) q[n].delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (sif.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", sif.valid_out); end
        n_tests++;
        if (sif.info_out !== '0) begin n_fail++; $display("FAIL reset_info_out: got %h want 0", sif.info_out); end
        n_tests++;
        if (sif.id_out !== 2'd0) begin n_fail++; $display("FAIL reset_id_out: got %0d want 0", sif.id_out); end
        n_tests++;
        if (w_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", w_busy); end
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        w = 128'hA5000000_00000000_00000000_00000001;
        do_reset();
        q[2].push_back(w);
        tick();
        n_tests++;
        if (w_busy !== 4'b0100) begin n_fail++; $display("FAIL single_busy_set: got %b want 0100", w_busy); end
        n_tests++;
        if (sif.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", sif.valid_out); end
        tick();
        n_tests++;
        if (w_busy !== 4'b0000) begin n_fail++; $display("FAIL single_busy_clear: got %b want 0000", w_busy); end
        n_tests++;
        if (sif.valid_out !== 1'b1 || sif.id_out !== 2'd2) begin
            n_fail++; $display("FAIL single_out: got valid %b id %0d want valid 1 id 2", sif.valid_out, sif.id_out);
        end
        n_tests++;
        if (sif.info_out !== w) begin n_fail++; $display("FAIL single_info: got %h want %h", sif.info_out, w); end
        tick();
        n_tests++;
        if (sif.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_valid_len: got %b want 0", sif.valid_out); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int n = 0; n < 4; n++) q[n].push_back(wd(n, 0));
        tick();
        n_tests++;
        if (w_busy !== 4'b1111) begin n_fail++; $display("FAIL simul_busy: got %b want 1111", w_busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (sif.valid_out !== 1'b1 || sif.id_out !== 2'(k)) begin
                n_fail++; $display("FAIL simul_id_%0d: got valid %b id %0d want valid 1 id %0d", k, sif.valid_out, sif.id_out, k);
            end
            n_tests++;
            if (sif.info_out !== wd(k, 0)) begin
                n_fail++; $display("FAIL simul_info_%0d: got %h want %h", k, sif.info_out, wd(k, 0));
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int ch;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            q[1].push_back(wd(1, k));
            q[3].push_back(wd(3, k));
        end
        drain(12, 60, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rr_drain: got %0d words want 12", rx.size()); end
        for (int i = 0; i < rx.size() && i < 12; i++) begin
            ch = (i % 2 == 1) ? 3 : 1;
            n_tests++;
            if (rx[i].id !== 2'(ch) || rx[i].info !== wd(ch, i / 2)) begin
                n_fail++; $display("FAIL rr_word_%0d: got id %0d info %h want id %0d info %h", i, rx[i].id, rx[i].info, ch, wd(ch, i / 2));
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int left;
        do_reset();
        for (int n = 0; n < 4; n++)
            for (int k = 0; k < 3; k++) q[n].push_back(wd(n, k));
        ds_busy = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t >= 2) begin
                n_tests++;
                if (sif.valid_out !== 1'b1 || sif.id_out !== 2'd0 || sif.info_out !== wd(0, 0)) begin
                    n_fail++; $display("FAIL stall_frozen_t%0d: got valid %b id %0d info %h want 1 0 %h", t, sif.valid_out, sif.id_out, sif.info_out, wd(0, 0));
                end
            end
            if (t >= 3) begin
                n_tests++;
                if (w_busy !== 4'b1111) begin n_fail++; $display("FAIL stall_busy_t%0d: got %b want 1111", t, w_busy); end
            end
        end
        left = 0;
        for (int n = 0; n < 4; n++) left += q[n].size();
        n_tests++;
        if (left != 7) begin n_fail++; $display("FAIL stall_buffered: got %0d words pending want 7", left); end
        ds_busy = 1'b0;
        drain(12, 60, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stall_drain: got %0d words want 12", rx.size()); end
        for (int i = 0; i < rx.size() && i < 12; i++) begin
            n_tests++;
            if (rx[i].id !== 2'(i % 4) || rx[i].info !== wd(i % 4, i / 4)) begin
                n_fail++; $display("FAIL stall_word_%0d: got id %0d info %h want id %0d info %h", i, rx[i].id, rx[i].info, i % 4, wd(i % 4, i / 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        for (int k = 0; k < 8; k++) q[0].push_back(wd(0, k + 16));
        drain(8, 40, ok);
        n_tests++;
        if (!ok || acc0.size() != 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d out %0d accepted want 8 8", rx.size(), acc0.size());
        end
        for (int i = 0; i + 1 < acc0.size(); i++) begin
            n_tests++;
            if (acc0[i + 1] - acc0[i] != 2) begin
                n_fail++; $display("FAIL b2b_spacing_%0d: got %0d cycles want 2", i, acc0[i + 1] - acc0[i]);
            end
        end
        for (int i = 0; i < rx.size() && i < 8; i++) begin
            n_tests++;
            if (rx[i].id !== 2'd0 || rx[i].info !== wd(0, i + 16)) begin
                n_fail++; $display("FAIL b2b_word_%0d: got id %0d info %h want id 0 info %h", i, rx[i].id, rx[i].info, wd(0, i + 16));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ds_busy = 1'b1;
        q[1].push_back(wd(1, 0));
        q[1].push_back(wd(1, 1));
        q[2].push_back(wd(2, 0));
        q[3].push_back(wd(3, 0));
        q[3].push_back(wd(3, 1));
        tick();
        tick();
        tick();
        n_tests++;
        if (sif.valid_out !== 1'b1 || w_busy !== 4'b1110) begin
            n_fail++; $display("FAIL rstmid_setup: got valid %b busy %b want 1 1110", sif.valid_out, w_busy);
        end
        for (int n = 0; n < 4; n++) q[n].delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (sif.valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", sif.valid_out); end
        n_tests++;
        if (w_busy !== 4'b0000) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0000", w_busy); end
        ds_busy = 1'b0;
        q[0].push_back(wd(0, 5));
        q[2].push_back(wd(2, 5));
        tick();
        tick();
        n_tests++;
        if (sif.valid_out !== 1'b1 || sif.id_out !== 2'd0 || sif.info_out !== wd(0, 5)) begin
            n_fail++; $display("FAIL rstmid_grant: got valid %b id %0d info %h want 1 0 %h", sif.valid_out, sif.id_out, sif.info_out, wd(0, 5));
        end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) tb_info[n] = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/status_arbiter.md
# status_arbiter

Four-channel round-robin arbiter that merges the four status streams (id0..id3, 128-bit info plus valid) into a single registered 128-bit stream tagged with its source id. It sits upstream of `status_splitter` and drives one of its channels. It honours that block's busy backpressure, so the splitter's consumers never lose a status word. Each input channel has a one-entry holding slot, so a requester is released as soon as its word is captured, independent of downstream stalls on other channels.

## Interface
- `DATA_W`, 128: info width per channel.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `info_in_id0..id3`  in  DATA_W each  status words from requesters 0..3.
- `valid_in_id0..id3`  in  1 each  requester N presents a word.
- `busy_id0..id3`  out  1 each  slot N is full; requester N must hold `info`/`valid`.
- `info_out`  out  DATA_W  granted word, registered.
- `valid_out`  out  1  `info_out` holds a word.
- `id_out`  out  2  source channel of `info_out`.
- `downstream_busy`  in  1  consumer stall; the `upstream_busy` of `status_splitter`.

## Operation
- Handshake on every port: a transfer occurs on a rising edge where valid=1 and busy=0. The source holds data and valid while busy=1. Valid is never withdrawn before transfer.
- Slot N: `full[N]` and `data[N]`. `busy_idN = full[N]`, straight from the flop.
  - Capture: `valid_in_idN & ~full[N]` → `data[N] <= info_in_idN`, `full[N] <= 1`.
  - Release: `full[N] <= 0` when slot N is granted.
  - Capture and release never coincide on one slot: busy=1 blocks capture.
- Output register `{valid_out, info_out, id_out}`. `load = (~valid_out | ~downstream_busy) & (|full)`.
  - On load, the granted slot is moved into the output register, `valid_out <= 1`, and `id_out <= grant`.
  - With no load, if `valid_out & ~downstream_busy`, then `valid_out <= 0`. `info_out`/`id_out` keep their last value.
  - While `valid_out & downstream_busy`, the output register is frozen.
- Round-robin: 2-bit `last` pointer.
  - The search order is `last+1, last+2, last+3, last` (mod 4). The first full slot wins.
  - `last <= grant` only on load.
  - A channel that was just granted has lowest priority on the next load.
- Only registered slot state takes part in arbitration. A word arriving on edge T cannot be granted on edge T.
- No word is dropped or duplicated. Per-channel order is preserved. Between channels, order is round-robin, not arrival order.

## Timing
- Reset values:
  - `full[3:0]=0` and `busy_id0..3=0`.
  - `valid_out=0`, `info_out=0`, `id_out=0`.
  - `last=3`, so channel 0 has first priority after reset.
  - `data[*]` is don't-care.
- Reset asserted mid-operation discards all slot and output contents on that edge. Requesters see busy=0 on the following cycle.
- Latency: input accepted on edge T → `full` set after T → loaded on edge T+1 → `valid_out=1` during cycle T+1..T+2 if `downstream_busy=0`.
- Per-channel throughput is one word per 2 cycles, because busy is registered feedback. Aggregate throughput is one word per cycle when two or more slots are kept full.
- Output transfer with `downstream_busy=0` and another slot full: reload on the same edge, so there is no bubble.
- `downstream_busy` held high: after the output register fills, each slot can absorb one more word, then its busy asserts. At most 5 words are buffered in total.
- All four slots full and the output stalled: all busy outputs are 1, and there is no state change until `downstream_busy` falls.

## Test plan
- **Single word.** Stimulus: reset, then `valid_in_id2=1`, `info=128'hA5…01` for one accepted edge. Required response:
  - `busy_id2` is high for exactly 1 cycle.
  - `valid_out=1`, `id_out=2`, `info_out=128'hA5…01` one cycle later, valid for 1 cycle.
- **Simultaneous requests.** Stimulus: all four valid on the same edge with distinct words, `downstream_busy=0`. Required response:
  - Outputs appear on 4 consecutive cycles with `id_out` 0,1,2,3.
  - The data matches each source.
- **Round-robin fairness.** Stimulus: channels 1 and 3 continuously valid, `downstream_busy=0`. Required response: `id_out` alternates 1,3,1,3… with no channel granted twice in a row.
- **Stall.** Stimulus: `downstream_busy=1` for 10 cycles while all channels keep sending. Required response:
  - The output stays frozen on the first word.
  - After 2 cycles all `busy_idN=1`.
  - After release, 5 words drain in RR order with none lost or duplicated.
- **Back-to-back on one channel.** Stimulus: channel 0 valid continuously for 8 words. Required response: accepted every 2nd cycle, and `info_out` order equals send order.
- **Reset mid-burst.** Stimulus: assert `rst` for 1 cycle while 3 slots are full and `valid_out=1`. Required response:
  - Next cycle: `valid_out=0` and all busy=0.
  - Next grant is channel 0 if it is requesting.
